serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 14 +
 rtl/serial_adder_fa_cell.sv | 13 +
 rtl/serial_adder.sv | 135 +++++++++++++
 tb/tb_serial_adder.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and limits for the bit-serial adder.
// Used by serial_adder whether or not SERIAL_ADDER_SUB_EN is defined.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 64;

endpackage

// File: rtl/serial_adder_fa_cell.sv
// Combinational 1-bit full adder; the only arithmetic in the serial datapath.
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one operand bit per cycle, LSB first, valid/ready on both sides.
// Define SERIAL_ADDER_SUB_EN to add the op_sub input (a - b via inverted b, carry-in 1).
//
// state   | meaning
// IDLE    | waiting for operands, in_ready=1
// RUN     | one bit per cycle through fa_cell, busy=1
// DONE    | result presented, out_valid=1 until out_ready
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             op_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("serial_adder: WIDTH out of legal range");
    end

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [WIDTH-1:0]   res_shift;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               bit_s, bit_co;
    logic               sub_sel;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_sel = op_sub;
`else
    assign sub_sel = 1'b0;
`endif

    fa_cell u_fa_cell (
        .x  (a_q[0]),
        .y  (b_q[0]),
        .ci (carry_q),
        .s  (bit_s),
        .co (bit_co)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        sum_d     = sum_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        cout_d    = cout_q;
        // The new result bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
        res_shift = res_q >> 1;
        res_shift[WIDTH-1] = bit_s;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub_sel}};
                    carry_d = sub_sel ? 1'b1 : cin;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                res_d   = res_shift;
                carry_d = bit_co;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    sum_d   = res_shift;
                    cout_d  = bit_co;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_RUN);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8); subtraction scenario runs when
// SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         op_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [W:0] exp_q[$];

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .op_sub    (op_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: full (W+1)-bit result of the requested operation.
    function automatic logic [W:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                         input logic ci, input logic sub);
        logic [W:0] r;
        if (sub) r = {1'b0, av} + {1'b0, ~bv} + (W+1)'(1);
        else     r = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, ci};
        return r;
    endfunction

    // Present one operand set for exactly one accepting edge; caller starts #1 after an edge in IDLE.
    task automatic accept(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                          input logic sub, input bit push);
        if (push) exp_q.push_back(model(av, bv, ci, sub));
        a = av; b = bv; cin = ci; op_sub = sub;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Edges counted including the accepting edge; bounded so a stuck DUT cannot hang the run.
    task automatic wait_valid(output int edges);
        edges = 1;
        while (!out_valid && edges < 200) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, busy, cout, sum} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ov=%b busy=%b cout=%b sum=%h, want all zero",
                     out_valid, busy, cout, sum);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_add();
        int edges;
        logic [W:0] e;
        accept(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL add_busy: got busy=%b in_ready=%b want 1/0", busy, in_ready);
        end
        wait_valid(edges);
        n_cmp++;
        if (edges !== W + 1) begin
            n_fail++;
            $display("FAIL add_latency: got %0d edges want %0d", edges, W + 1);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if ({cout, sum} !== e || e !== 9'h096) begin
            n_fail++;
            $display("FAIL add_result: got cout=%b sum=%h want %h", cout, sum, e);
        end
        handshake();
    endtask

    task automatic test_carry();
        logic [W-1:0] av[2] = '{8'hFF, 8'hFF};
        logic [W-1:0] bv[2] = '{8'h01, 8'hFF};
        logic         cv[2] = '{1'b0, 1'b1};
        int edges;
        logic [W:0] e;
        for (int i = 0; i < 2; i++) begin
            accept(av[i], bv[i], cv[i], 1'b0, 1'b1);
            wait_valid(edges);
            e = exp_q.pop_front();
            n_cmp++;
            if (out_valid !== 1'b1 || {cout, sum} !== e) begin
                n_fail++;
                $display("FAIL carry_%0d: got ov=%b cout=%b sum=%h want %h", i, out_valid, cout, sum, e);
            end
            handshake();
        end
    endtask

    task automatic test_backpressure();
        int edges;
        logic [W:0] e;
        logic [W:0] hold;
        out_ready = 1'b0;
        accept(8'h81, 8'h7F, 1'b1, 1'b0, 1'b1);
        wait_valid(edges);
        e = exp_q.pop_front();
        hold = {cout, sum};
        n_cmp++;
        if (out_valid !== 1'b1 || hold !== e) begin
            n_fail++;
            $display("FAIL bp_result: got ov=%b value=%h want %h", out_valid, hold, e);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({cout, sum} !== e || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: got value=%h ov=%b ir=%b want %h/1/0",
                         i, {cout, sum}, out_valid, in_ready, e);
            end
        end
        handshake();
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || {cout, sum} !== e) begin
            n_fail++;
            $display("FAIL bp_release: got ir=%b ov=%b value=%h want 1/0/%h",
                     in_ready, out_valid, {cout, sum}, e);
        end
    endtask

    task automatic test_busy();
        int edges;
        logic [W:0] e;
        bit leaked;
        accept(8'h33, 8'h44, 1'b1, 1'b0, 1'b1);
        a = 8'hAA; b = 8'hBB; cin = 1'b0;
        in_valid = 1'b1;
        leaked = 1'b0;
        edges = 1;
        while (!out_valid && edges < 200) begin
            if (in_ready !== 1'b0) leaked = 1'b1;
            @(posedge clk); #1;
            edges++;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (leaked) begin
            n_fail++;
            $display("FAIL busy_in_ready: got in_ready=1 during RUN want 0");
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (out_valid !== 1'b1 || {cout, sum} !== e) begin
            n_fail++;
            $display("FAIL busy_result: got ov=%b value=%h want %h", out_valid, {cout, sum}, e);
        end
        handshake();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_no_capture: got busy=%b ov=%b want 0/0", busy, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        int edges;
        logic [W:0] e;
        bit spurious;
        accept(8'hC3, 8'h5D, 1'b1, 1'b0, 1'b0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, busy, cout, sum} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got ov=%b busy=%b cout=%b sum=%h want all zero",
                     out_valid, busy, cout, sum);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_idle: got in_ready=%b want 1", in_ready);
        end
        spurious = 1'b0;
        for (int i = 0; i < W + 3; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || busy !== 1'b0) spurious = 1'b1;
        end
        n_cmp++;
        if (spurious) begin
            n_fail++;
            $display("FAIL mid_reset_abandon: got activity after reset want none");
        end
        accept(8'h01, 8'h02, 1'b0, 1'b0, 1'b1);
        wait_valid(edges);
        e = exp_q.pop_front();
        n_cmp++;
        if (out_valid !== 1'b1 || {cout, sum} !== e || e !== 9'h003) begin
            n_fail++;
            $display("FAIL mid_reset_next: got ov=%b value=%h want %h", out_valid, {cout, sum}, e);
        end
        handshake();
    endtask

    task automatic test_back_to_back();
        int edges;
        logic [W:0] e;
        logic [W-1:0] av, bv;
        logic ci;
        for (int i = 0; i < 6; i++) begin
            av = W'($urandom);
            bv = W'($urandom);
            ci = 1'($urandom);
            out_ready = 1'b0;
            accept(av, bv, ci, 1'b0, 1'b1);
            wait_valid(edges);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            e = exp_q.pop_front();
            n_cmp++;
            if (out_valid !== 1'b1 || {cout, sum} !== e) begin
                n_fail++;
                $display("FAIL b2b_%0d: a=%h b=%h cin=%b got ov=%b value=%h want %h",
                         i, av, bv, ci, out_valid, {cout, sum}, e);
            end
            handshake();
        end
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_sub();
        logic [W-1:0] av[2] = '{8'h10, 8'h20};
        logic [W-1:0] bv[2] = '{8'h20, 8'h10};
        logic [W:0]   want[2] = '{9'h0F0, 9'h110};
        int edges;
        logic [W:0] e;
        for (int i = 0; i < 2; i++) begin
            accept(av[i], bv[i], 1'b0, 1'b1, 1'b1);
            wait_valid(edges);
            e = exp_q.pop_front();
            n_cmp++;
            if (out_valid !== 1'b1 || {cout, sum} !== e || e !== want[i]) begin
                n_fail++;
                $display("FAIL sub_%0d: got ov=%b value=%h want %h", i, out_valid, {cout, sum}, want[i]);
            end
            handshake();
        end
        op_sub = 1'b0;
    endtask
`endif

    initial begin
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        op_sub    = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_add();
        test_carry();
        test_backpressure();
        test_busy();
        test_reset_mid();
        test_back_to_back();
`ifdef SERIAL_ADDER_SUB_EN
        test_sub();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
